dic_ctrl: RTL and testbench

DIC_CTRL -- requirements
Module: dic_ctrl

---
 rtl/dic_pkg.sv | 34 +++
 rtl/ascii_digit_dec.sv | 23 ++
 rtl/dic_ctrl_chk.sv | 21 ++
 rtl/dic_ctrl.sv | 131 +++++++++++++
 tb/tb_dic_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/dic_pkg.sv
// Shared codes, limits and the load-sequence state type for the digital clock command controller.
package dic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_MT = 3'd1,
    LD_MO = 3'd2,
    LD_ST = 3'd3,
    LD_SO = 3'd4
  } dicState_e;

  localparam logic [7:0] ASCII_R   = 8'h72;
  localparam logic [7:0] ASCII_S   = 8'h73;
  localparam logic [7:0] ASCII_D   = 8'h64;
  localparam logic [7:0] ASCII_L   = 8'h6C;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;

  localparam logic [3:0] TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX = 4'd9;

  // Tens positions of minutes and seconds only reach 5; ones positions reach 9.
  function automatic logic [3:0] digitLimit(input dicState_e st);
    logic [3:0] lim;
    case (st)
      LD_MT:   lim = TENS_MAX;
      LD_ST:   lim = TENS_MAX;
      default: lim = ONES_MAX;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/ascii_digit_dec.sv
// Combinational ASCII decimal-digit decoder: flags '0'..'9' and returns its binary value.
module ascii_digit_dec
  import dic_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_digit,
  output logic [3:0] value
);

  // Digit detect and value extraction; non-digits yield value 0.
  always_comb begin
    is_digit = 1'b0;
    value    = 4'd0;
    if ((rx_data >= ASCII_0) && (rx_data <= ASCII_9)) begin
      is_digit = 1'b1;
      value    = rx_data[3:0];
    end else begin
      is_digit = 1'b0;
      value    = 4'd0;
    end
  end

endmodule

// File: rtl/dic_ctrl_chk.sv
// Property checker for dic_ctrl outputs: strobe exclusivity and frozen clock during loads.
module dic_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic dicRun,
  input logic ldMtens,
  input logic ldMones,
  input logic ldStens,
  input logic ldSones,
  input logic ld_busy
);

  strobeOneHot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ldMtens, ldMones, ldStens, ldSones}))
    else $error("FAIL strobeOneHot0 more than one ld strobe high");

  runFrozenWhileBusy: assert property (@(posedge clk) disable iff (rst)
    ld_busy |-> !dicRun)
    else $error("FAIL runFrozenWhileBusy dicRun high during load");

endmodule

// File: rtl/dic_ctrl.sv
// Command decoder for the digital clock: run/stop, display select and a four-digit time-load sequence.
module dic_ctrl
  import dic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       dicRun,
  output logic       dicSelectLEDdisp,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       ld_busy
);

  dicState_e  state_r;
  dicState_e  nextState_s;
  logic       runSaved_r;
  logic       nextRunSaved_s;
  logic       nextRun_s;
  logic       nextSel_s;
  logic [3:0] nextLd_s;
  logic [3:0] nextNum_s;
  logic       isDigit_s;
  logic [3:0] digitVal_s;

  ascii_digit_dec uDigitDec (
    .rx_data  (rx_data),
    .is_digit (isDigit_s),
    .value    (digitVal_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state and next-output decode; bytes only act on rx_valid cycles.
  always_comb begin
    nextState_s    = state_r;
    nextRun_s      = dicRun;
    nextRunSaved_s = runSaved_r;
    nextSel_s      = dicSelectLEDdisp;
    nextLd_s       = 4'b0000;
    nextNum_s      = 4'd0;
    if (rx_valid) begin
      if (state_r == IDLE) begin
        case (rx_data)
          ASCII_R: nextRun_s = 1'b1;
          ASCII_S: nextRun_s = 1'b0;
          ASCII_D: nextSel_s = ~dicSelectLEDdisp;
          ASCII_L: begin
            nextRunSaved_s = dicRun;
            nextRun_s      = 1'b0;
            nextState_s    = LD_MT;
          end
          default: nextState_s = IDLE;
        endcase
      end else if (rx_data == ASCII_ESC) begin
        nextState_s = IDLE;
        nextRun_s   = runSaved_r;
      end else if (rx_data == ASCII_L) begin
        // Restart keeps the run state captured on the original entry.
        nextState_s = LD_MT;
      end else if (isDigit_s && (digitVal_s <= digitLimit(state_r))) begin
        nextNum_s = digitVal_s;
        case (state_r)
          LD_MT: begin
            nextLd_s    = 4'b1000;
            nextState_s = LD_MO;
          end
          LD_MO: begin
            nextLd_s    = 4'b0100;
            nextState_s = LD_ST;
          end
          LD_ST: begin
            nextLd_s    = 4'b0010;
            nextState_s = LD_SO;
          end
          LD_SO: begin
            nextLd_s    = 4'b0001;
            nextState_s = IDLE;
            nextRun_s   = runSaved_r;
          end
          default: begin
            nextLd_s    = 4'b0000;
            nextNum_s   = 4'd0;
            nextState_s = IDLE;
          end
        endcase
      end else begin
        nextState_s = state_r;
      end
    end else begin
      nextState_s = state_r;
    end
  end

  // Output and saved-run registers; strobes appear the cycle after the accepting byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      runSaved_r       <= 1'b0;
      dicRun           <= 1'b0;
      dicSelectLEDdisp <= 1'b0;
      ldMtens          <= 1'b0;
      ldMones          <= 1'b0;
      ldStens          <= 1'b0;
      ldSones          <= 1'b0;
      ld_num           <= 4'd0;
      ld_busy          <= 1'b0;
    end else begin
      runSaved_r       <= nextRunSaved_s;
      dicRun           <= nextRun_s;
      dicSelectLEDdisp <= nextSel_s;
      ldMtens          <= nextLd_s[3];
      ldMones          <= nextLd_s[2];
      ldStens          <= nextLd_s[1];
      ldSones          <= nextLd_s[0];
      ld_num           <= nextNum_s;
      ld_busy          <= (nextState_s != IDLE);
    end
  end

endmodule

// File: tb/tb_dic_ctrl.sv
// Directed self-checking bench for dic_ctrl with hand-computed expected outputs.
module tb_dic_ctrl;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       dicRun;
  logic       dicSelectLEDdisp;
  logic       ldMtens;
  logic       ldMones;
  logic       ldStens;
  logic       ldSones;
  logic [3:0] ld_num;
  logic       ld_busy;

  int testsRun;
  int testsFailed;
  logic multiHotSeen;

  dic_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .dicRun           (dicRun),
    .dicSelectLEDdisp (dicSelectLEDdisp),
    .ldMtens          (ldMtens),
    .ldMones          (ldMones),
    .ldStens          (ldStens),
    .ldSones          (ldSones),
    .ld_num           (ld_num),
    .ld_busy          (ld_busy)
  );

  dic_ctrl_chk uChk (
    .clk     (clk),
    .rst     (rst),
    .dicRun  (dicRun),
    .ldMtens (ldMtens),
    .ldMones (ldMones),
    .ldStens (ldStens),
    .ldSones (ldSones),
    .ld_busy (ld_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky record of any cycle with more than one strobe high.
  always @(negedge clk) begin
    if (!rst && !$onehot0({ldMtens, ldMones, ldStens, ldSones})) multiHotSeen = 1'b1;
  end

  task automatic chkOut(input string tag, input logic expRun, input logic expSel,
                        input logic [3:0] expLd, input logic [3:0] expNum, input logic expBusy);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {dicRun, dicSelectLEDdisp, ldMtens, ldMones, ldStens, ldSones, ld_num, ld_busy};
    exp = {expRun, expSel, expLd, expNum, expBusy};
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%b expected=%b (run,sel,ld4,num,busy)", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the negedge after it was sampled.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    multiHotSeen = 1'b0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chkOut("reset", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);

    // run / stop
    sendByte(8'h72); chkOut("run_r", 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    sendByte(8'h73); chkOut("stop_s", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);

    // full load with clock running
    sendByte(8'h72); chkOut("run_again", 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    sendByte(8'h6C); chkOut("load_enter", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h31); chkOut("ld_mt_1", 1'b0, 1'b0, 4'b1000, 4'd1, 1'b1);
    @(negedge clk);  chkOut("strobe_one_cycle", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h32); chkOut("ld_mo_2", 1'b0, 1'b0, 4'b0100, 4'd2, 1'b1);
    sendByte(8'h33); chkOut("ld_st_3", 1'b0, 1'b0, 4'b0010, 4'd3, 1'b1);
    sendByte(8'h34); chkOut("ld_so_4_restore", 1'b1, 1'b0, 4'b0001, 4'd4, 1'b0);

    // illegal tens digit and non-digit ignored, then legal boundary 5
    sendByte(8'h6C); chkOut("load_enter2", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h37); chkOut("mt_7_ignored", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h78); chkOut("mt_x_ignored", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h35); chkOut("ld_mt_5", 1'b0, 1'b0, 4'b1000, 4'd5, 1'b1);
    sendByte(8'h1B); chkOut("esc_restore_run1", 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);

    // abort with clock stopped, then display toggle
    sendByte(8'h73); chkOut("stop_s2", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);
    sendByte(8'h6C); chkOut("load_enter3", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h33); chkOut("ld_mt_3", 1'b0, 1'b0, 4'b1000, 4'd3, 1'b1);
    sendByte(8'h1B); chkOut("esc_restore_run0", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);
    sendByte(8'h64); chkOut("disp_toggle", 1'b0, 1'b1, 4'b0000, 4'd0, 1'b0);

    // reset collides with digit in LD_MO
    sendByte(8'h6C); chkOut("load_enter4", 1'b0, 1'b1, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h31); chkOut("ld_mt_1b", 1'b0, 1'b1, 4'b1000, 4'd1, 1'b1);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h32;
    rst      = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b0;
    chkOut("rst_over_digit", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);
    @(negedge clk);  chkOut("rst_no_late_strobe", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);

    // restart mid-load keeps saved run state
    sendByte(8'h72); chkOut("run_r3", 1'b1, 1'b0, 4'b0000, 4'd0, 1'b0);
    sendByte(8'h6C); chkOut("load_enter5", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h30); chkOut("ld_mt_0", 1'b0, 1'b0, 4'b1000, 4'd0, 1'b1);
    sendByte(8'h6C); chkOut("restart_l", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h72); chkOut("r_ignored_in_load", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h31); chkOut("restart_ld_mt_1", 1'b0, 1'b0, 4'b1000, 4'd1, 1'b1);
    sendByte(8'h39); chkOut("ld_mo_9", 1'b0, 1'b0, 4'b0100, 4'd9, 1'b1);
    sendByte(8'h36); chkOut("st_6_ignored", 1'b0, 1'b0, 4'b0000, 4'd0, 1'b1);
    sendByte(8'h35); chkOut("ld_st_5", 1'b0, 1'b0, 4'b0010, 4'd5, 1'b1);
    sendByte(8'h39); chkOut("ld_so_9_restore", 1'b1, 1'b0, 4'b0001, 4'd9, 1'b0);

    testsRun++;
    assert (multiHotSeen === 1'b0) else begin
      testsFailed++;
      $error("FAIL strobe_exclusive observed=%b expected=%b", multiHotSeen, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
